// File: rtl/board_cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : board_cursor_ctrl
// Purpose  : Two-player board controller: button event detection, cursor,
//            occupancy masks and turn. Macro BOARD_SKIP_OCCUPIED_EN makes the
//            cursor skip occupied cells and auto-advance after a place.
// Revision : 1.0
// ============================================================================
module board_cursor_ctrl #(
  parameter int ROWS = 3,
  parameter int COLS = 3,
  localparam int CELLS = ROWS * COLS,
  localparam int IW = $clog2(CELLS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_next_n,
  input  logic             btn_place_n,
  input  logic             clear,
  output logic [CELLS-1:0] board_p1,
  output logic [CELLS-1:0] board_p2,
  output logic [IW-1:0]    cursor,
  output logic             turn,
  output logic             load,
  output logic             reject,
  output logic             full
);

  localparam logic [IW-1:0] c_last = IW'(CELLS - 1);
  localparam logic [IW-1:0] c_one  = IW'(1);

  typedef enum logic [0:0] {
    ST_PLAY = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t           r_state;

  // Button pipelines: bit 0 = next, bit 1 = place.
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_prev;
  logic [2:0]       r_live;
  logic [1:0]       w_press;

  logic             w_next_ev;
  logic             w_place_ev;
  logic             w_place_ok;
  logic             w_place_rej;
  logic [CELLS-1:0] w_occ;
  logic [CELLS-1:0] w_p1_nxt;
  logic [CELLS-1:0] w_p2_nxt;
  logic [CELLS-1:0] w_occ_nxt;
  logic [IW-1:0]    w_cursor_nxt;

  // r_live marks when r_prev holds a genuine post-reset sample, so a button
  // held across reset release cannot masquerade as a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
      r_live  <= '0;
    end else begin
      r_sync1 <= {btn_place_n, btn_next_n};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_live  <= {r_live[1:0], 1'b1};
    end
  end

  assign w_press    = r_live[2] ? (r_prev & ~r_sync2) : 2'b00;
  assign w_next_ev  = w_press[0];
  assign w_place_ev = w_press[1];

`ifdef BOARD_SKIP_OCCUPIED_EN
  // Nearest free cell walking downward (with wrap) from cell-1; holds if none.
  function automatic logic [IW-1:0] find_free(input logic [IW-1:0]    from,
                                              input logic [CELLS-1:0] occ);
    logic [IW-1:0] cand;
    logic [IW-1:0] pick;
    logic          found;
    cand  = from;
    pick  = from;
    found = 1'b0;
    for (int k = 0; k < CELLS; k++) begin
      cand = (cand == '0) ? c_last : cand - c_one;
      if (!found && !occ[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction
`endif

  always_comb begin
    w_occ       = board_p1 | board_p2;
    w_place_ok  = w_place_ev && (r_state == ST_PLAY) && !w_occ[cursor];
    w_place_rej = w_place_ev && !w_place_ok;
    w_p1_nxt    = board_p1;
    w_p2_nxt    = board_p2;
    if (w_place_ok) begin
      if (turn) begin
        w_p2_nxt[cursor] = 1'b1;
      end else begin
        w_p1_nxt[cursor] = 1'b1;
      end
    end
    w_occ_nxt = w_p1_nxt | w_p2_nxt;
`ifdef BOARD_SKIP_OCCUPIED_EN
    // The search sees the freshly written cell, so a simultaneous place and
    // move never lands back on the cell just taken.
    w_cursor_nxt = (w_next_ev || w_place_ok) ? find_free(cursor, w_occ_nxt) : cursor;
`else
    w_cursor_nxt = w_next_ev ? ((cursor == '0) ? c_last : cursor - c_one) : cursor;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_PLAY;
      board_p1 <= '0;
      board_p2 <= '0;
      cursor   <= c_last;
      turn     <= 1'b0;
      load     <= 1'b0;
      reject   <= 1'b0;
      full     <= 1'b0;
    end else if (clear) begin
      r_state  <= ST_PLAY;
      board_p1 <= '0;
      board_p2 <= '0;
      cursor   <= c_last;
      turn     <= 1'b0;
      load     <= 1'b0;
      reject   <= 1'b0;
      full     <= 1'b0;
    end else begin
      board_p1 <= w_p1_nxt;
      board_p2 <= w_p2_nxt;
      cursor   <= w_cursor_nxt;
      turn     <= turn ^ w_place_ok;
      load     <= w_place_ok;
      reject   <= w_place_rej;
      if (w_place_ok && (&w_occ_nxt)) begin
        r_state <= ST_DONE;
        full    <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_board_cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_cursor_ctrl
// Purpose  : Self-checking bench for board_cursor_ctrl (3x3): directed
//            scenarios plus random button activity against a cell-array model.
// Revision : 1.0
// ============================================================================
module tb_board_cursor_ctrl;

  localparam int CELLS = 9;
  localparam int IW    = 4;

  logic             clk         = 1'b0;
  logic             rst_n       = 1'b0;
  logic             btn_next_n  = 1'b1;
  logic             btn_place_n = 1'b1;
  logic             clear       = 1'b0;
  logic [CELLS-1:0] board_p1;
  logic [CELLS-1:0] board_p2;
  logic [IW-1:0]    cursor;
  logic             turn;
  logic             load;
  logic             reject;
  logic             full;

  int n_chk  = 0;
  int n_fail = 0;
  int n_load = 0;
  int n_rej  = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  board_cursor_ctrl #(.ROWS(3), .COLS(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_next_n (btn_next_n),
    .btn_place_n(btn_place_n),
    .clear      (clear),
    .board_p1   (board_p1),
    .board_p2   (board_p2),
    .cursor     (cursor),
    .turn       (turn),
    .load       (load),
    .reject     (reject),
    .full       (full)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int owner [CELLS] = '{default: 0};   // 0 free, 1 player 1, 2 player 2
  int m_cur  = CELLS - 1;
  bit m_turn = 1'b0;
  bit m_full = 1'b0;
  bit m_ld   = 1'b0;
  bit m_rj   = 1'b0;
  bit qn[$];
  bit qp[$];

  task automatic m_clear();
    foreach (owner[i]) owner[i] = 0;
    m_cur  = CELLS - 1;
    m_turn = 1'b0;
    m_full = 1'b0;
    m_ld   = 1'b0;
    m_rj   = 1'b0;
  endtask

`ifdef BOARD_SKIP_OCCUPIED_EN
  function automatic int next_free(input int from);
    int c;
    c = from;
    for (int k = 0; k < CELLS; k++) begin
      c = (c == 0) ? CELLS - 1 : c - 1;
      if (owner[c] == 0) return c;
    end
    return from;
  endfunction
`endif

  task automatic m_step(input bit nev, input bit pev, input bit clr);
    bit placed;
    int cnt;
    placed = 1'b0;
    m_ld   = 1'b0;
    m_rj   = 1'b0;
    if (clr) begin
      m_clear();
      return;
    end
    if (pev) begin
      if (!m_full && owner[m_cur] == 0) begin
        owner[m_cur] = m_turn ? 2 : 1;
        m_turn = !m_turn;
        m_ld   = 1'b1;
        placed = 1'b1;
        cnt = 0;
        foreach (owner[i]) if (owner[i] != 0) cnt++;
        if (cnt == CELLS) m_full = 1'b1;
      end else begin
        m_rj = 1'b1;
      end
    end
`ifdef BOARD_SKIP_OCCUPIED_EN
    if (nev || placed) m_cur = next_free(m_cur);
`else
    if (nev) m_cur = (m_cur == 0) ? CELLS - 1 : m_cur - 1;
`endif
  endtask

  // A press is a genuine post-reset high sample followed by a low sample;
  // its effect lands two edges after the low sample.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_clear();
      qn.delete();
      qp.delete();
    end else begin
      int n;
      bit nev, pev;
      qn.push_back(btn_next_n);
      qp.push_back(btn_place_n);
      n   = qn.size();
      nev = (n >= 4) && qn[n-4] && !qn[n-3];
      pev = (n >= 4) && qp[n-4] && !qp[n-3];
      m_step(nev, pev, clear);
    end
  end

  logic [CELLS-1:0] e1, e2;
  always @(negedge clk) begin
    if (load === 1'b1)   n_load++;
    if (reject === 1'b1) n_rej++;
    if (cmp_en) begin
      for (int i = 0; i < CELLS; i++) begin
        e1[i] = (owner[i] == 1);
        e2[i] = (owner[i] == 2);
      end
      check("board_p1", board_p1, e1);
      check("board_p2", board_p2, e2);
      check("cursor", cursor, m_cur);
      check("turn", turn, m_turn);
      check("load", load, m_ld);
      check("reject", reject, m_rj);
      check("full", full, m_full);
      check("ld_rj_excl", load & reject, 0);
      check("mask_overlap", board_p1 & board_p2, 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic press(input bit nx, input bit pl, input int hold);
    @(negedge clk);
    if (nx) btn_next_n = 1'b0;
    if (pl) btn_place_n = 1'b0;
    repeat (hold) @(negedge clk);
    btn_next_n  = 1'b1;
    btn_place_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 8};
    int l0, r0;

    // Reset values
    @(negedge clk);
    cmp_en = 1'b1;
    check("rst_p1", board_p1, 0);
    check("rst_p2", board_p2, 0);
    check("rst_cursor", cursor, 8);
    check("rst_turn", turn, 0);
    check("rst_full", full, 0);
    check("rst_load", load, 0);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Cursor stepping, one step per long press
    for (int i = 0; i < 9; i++) begin
      press(1'b1, 1'b0, 20);
      check("next_seq", cursor, exp_seq[i]);
    end

    // Alternate placement
    l0 = n_load;
    press(1'b0, 1'b1, 20);
`ifndef BOARD_SKIP_OCCUPIED_EN
    press(1'b1, 1'b0, 20);
`endif
    press(1'b0, 1'b1, 20);
    check("alt_p1", board_p1, 9'h100);
    check("alt_p2", board_p2, 9'h080);
    check("alt_turn", turn, 0);
    check("alt_loads", n_load - l0, 2);
`ifdef BOARD_SKIP_OCCUPIED_EN
    check("alt_cursor", cursor, 6);
`else
    check("alt_cursor", cursor, 7);
`endif

    // Place on occupied cell
    pulse_clear();
`ifndef BOARD_SKIP_OCCUPIED_EN
    r0 = n_rej;
    press(1'b0, 1'b1, 20);
    press(1'b0, 1'b1, 20);
    check("occ_reject", n_rej - r0, 1);
    check("occ_p1", board_p1, 9'h100);
    check("occ_p2", board_p2, 9'h000);
    check("occ_turn", turn, 1);
    pulse_clear();
`endif

    // Fill the board
    l0 = n_load;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) check("not_full_yet", full, 0);
      press(1'b0, 1'b1, 20);
`ifndef BOARD_SKIP_OCCUPIED_EN
      if (i < 8) press(1'b1, 1'b0, 20);
`endif
    end
    check("fill_loads", n_load - l0, 9);
    check("fill_full", full, 1);
    check("fill_p1", board_p1, 9'h155);
    check("fill_p2", board_p2, 9'h0AA);
    r0 = n_rej;
    press(1'b0, 1'b1, 20);
    check("done_reject", n_rej - r0, 1);
    check("done_p1", board_p1, 9'h155);
    pulse_clear();
    check("clr_p1", board_p1, 0);
    check("clr_p2", board_p2, 0);
    check("clr_cursor", cursor, 8);
    check("clr_full", full, 0);

    // Simultaneous next and place
`ifdef BOARD_SKIP_OCCUPIED_EN
    repeat (4) press(1'b1, 1'b0, 20);
    press(1'b0, 1'b1, 20);
    press(1'b0, 1'b1, 20);
    repeat (6) press(1'b1, 1'b0, 20);
    check("sim_pre_cursor", cursor, 5);
    press(1'b1, 1'b1, 20);
    check("sim_p1", board_p1, 9'h030);
    check("sim_p2", board_p2, 9'h008);
    check("sim_cursor", cursor, 2);
`else
    repeat (3) press(1'b1, 1'b0, 20);
    check("sim_pre_cursor", cursor, 5);
    press(1'b1, 1'b1, 20);
    check("sim_p1", board_p1, 9'h020);
    check("sim_cursor", cursor, 4);
`endif

    // Reset mid-game with place held
    pulse_clear();
    press(1'b1, 1'b0, 5);
    press(1'b0, 1'b1, 5);
    @(negedge clk);
    btn_place_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_p1", board_p1, 0);
    check("mid_rst_cursor", cursor, 8);
    check("mid_rst_turn", turn, 0);
    check("mid_rst_load", load, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    l0 = n_load;
    repeat (10) @(negedge clk);
    check("held_no_load", n_load - l0, 0);
    check("held_p1", board_p1, 0);
    btn_place_n = 1'b1;
    repeat (4) @(negedge clk);
    press(1'b0, 1'b1, 5);
    check("repress_load", n_load - l0, 1);
    check("repress_p1", board_p1, 9'h100);

    // Random activity
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) btn_next_n = ~btn_next_n;
      if ($urandom_range(0, 3) == 0) btn_place_n = ~btn_place_n;
      clear = ($urandom_range(0, 149) == 0);
      if (c == 900) #2 rst_n = 1'b0;
      if (c == 903) #2 rst_n = 1'b1;
    end
    @(negedge clk);
    clear       = 1'b0;
    btn_next_n  = 1'b1;
    btn_place_n = 1'b1;
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/board_cursor_ctrl.md
BOARD_CURSOR_CTRL -- requirements
Module: board_cursor_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 3, board row count (range 2..8).
REQ-002 SHALL have parameter COLS, default 3, board column count (range 2..8); CELLS = ROWS*COLS; IW = clog2(CELLS).
REQ-003 SHALL have port clk  input  1  single system clock, all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port btn_next_n  input  1  active-low raw button, advance cursor.
REQ-006 SHALL have port btn_place_n  input  1  active-low raw button, place current player's mark at cursor.
REQ-007 SHALL have port clear  input  1  synchronous active-high board clear.
REQ-008 SHALL have port board_p1  output  CELLS  player-1 occupancy mask, bit i = cell i.
REQ-009 SHALL have port board_p2  output  CELLS  player-2 occupancy mask.
REQ-010 SHALL have port cursor  output  IW  selected cell index; CELLS-1 = top-left, 0 = bottom-right.
REQ-011 SHALL have port turn  output  1  0 = player 1 to move, 1 = player 2.
REQ-012 SHALL have port load  output  1  one-cycle pulse, a mark was written.
REQ-013 SHALL have port reject  output  1  one-cycle pulse, place attempted on occupied cell or in DONE.
REQ-014 SHALL have port full  output  1  high while state is DONE.

Function
REQ-015 SHALL pass each button through a 2-flop synchronizer plus a previous-value flop; a press event is the synchronized level going 1->0, one event per press regardless of hold length.
REQ-016 SHALL make press effects visible on the 3rd rising edge after the first edge sampling the button low; no other latency.
REQ-017 SHALL implement states PLAY and DONE; PLAY->DONE on the edge where the write makes (board_p1|board_p2) all ones; DONE->PLAY only on clear.
REQ-018 SHALL, on next event in PLAY or DONE, set cursor to cursor-1, wrapping 0 -> CELLS-1.
REQ-019 SHALL, on place event in PLAY with cell free, set bit cursor in board_p1 (turn=0) or board_p2 (turn=1), toggle turn, pulse load one cycle.
REQ-020 SHALL, on place event on an occupied cell or in DONE, leave board and turn unchanged and pulse reject one cycle.
REQ-021 SHALL, on simultaneous next and place events, perform the place at the pre-move cursor and the move on the same edge.
REQ-022 SHALL give clear priority over any same-cycle event: masks to 0, turn 0, cursor CELLS-1, state PLAY, load/reject 0; synchronizer flops unaffected.
REQ-023 SHALL never assert load and reject in the same cycle, and never set a bit in both masks.
REQ-024 SHALL keep cursor within 0..CELLS-1 for non-power-of-two CELLS.

Reset
REQ-025 SHALL on rst_n low immediately set board_p1=0, board_p2=0, cursor=CELLS-1, turn=0, load=0, reject=0, full=0, state PLAY, synchronizer and previous flops to 1 (released).
REQ-026 SHALL discard a press in progress during reset; a button held through reset release produces no event until released and pressed again.

Configuration
REQ-027 SHALL honour macro BOARD_SKIP_OCCUPIED_EN: when defined, next moves cursor to the nearest free cell in descending wrap order from cursor-1, holding cursor if no cell is free; after a successful place, cursor also auto-advances to the next free cell on the same edge.
REQ-028 SHALL, without BOARD_SKIP_OCCUPIED_EN, use plain decrement per REQ-018 and no auto-advance.

Verification
REQ-029 SHALL cover: reset, 9 next presses (3x3) -> cursor 8,7,...,0,8; each held 20 cycles gives exactly one step.
REQ-030 SHALL cover: place at 8, next, place at 7 -> board_p1=9'h100, board_p2=9'h080, turn=0, two load pulses.
REQ-031 SHALL cover: place twice at cursor 8 -> second gives reject pulse, masks and turn unchanged.
REQ-032 SHALL cover: fill all 9 cells alternately -> full=1 after 9th load; 10th place -> reject; clear -> masks 0, cursor 8, full 0.
REQ-033 SHALL cover: next and place events same cycle at cursor 5 -> bit 5 set, cursor 4; with BOARD_SKIP_OCCUPIED_EN and cells 4,3 occupied, cursor 2.
REQ-034 SHALL cover: rst_n low mid-game with btn_place_n held -> all outputs at reset values, no load after release until button re-pressed.
